axi_ar_arbiter: RTL
===================

Name: axi_ar_arbiter

Overview:
Read-address (AR) channel arbiter and router for the 2-master / 3-slave AXI interconnect; the control counterpart of the read-data (R) return mux.
- Grants one master at a time, with round-robin priority.
- Decodes ARADDR to slave0, slave1 or the default slave.
- Extends ARID with a one-hot master tag in IDS[5:4]: 01 = master0, 10 = master1. The R-channel mux routes responses on this tag.
- Allows one outstanding read per slave. A slave stays busy until its RLAST beat is handshaked.

Parameters:
S0_BASE, 32'h0000_0000, slave0 base address
S0_MASK, 32'hFFFF_0000, slave0 match mask; hit when (ARADDR & mask) == base
S1_BASE, 32'h0001_0000, slave1 base address
S1_MASK, 32'hFFFF_0000, slave1 match mask; no hit on slave0 or slave1 selects the default slave

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ARID_master0/1  in  `AXI_ID_BITS  master read ID
ARADDR_master0/1  in  `AXI_ADDR_BITS  read address
ARLEN_master0/1  in  `AXI_LEN_BITS  burst length
ARSIZE_master0/1  in  `AXI_SIZE_BITS  beat size
ARBURST_master0/1  in  2  burst type
ARVALID_master0/1  in  1  request valid
ARREADY_master0/1  out  1  request accepted
ARID_S  out  `AXI_IDS_BITS  {2'b00, tag[1:0], ARID}, shared to all slaves
ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as master  shared AR payload
ARVALID_slave0/1/Default  out  1  per-slave valid
ARREADY_slave0/1/Default  in  1  per-slave ready
RVALID_slave0/1/Default  in  1  observed R valid
RREADY_MtoS0/1/Default  in  1  observed R ready, from the R mux
RLAST_slave0/1/Default  in  1  observed R last

Behaviour:
- Reset (rst low, async):
  - state = IDLE; busy[2:0] = 0; priority pointer = master0.
  - All ARVALID_slave*, ARREADY_master* and shared payload outputs = 0.
- State IDLE:
  - A master is eligible when its ARVALID is 1 and its decoded target has busy = 0. Decoding is combinational on its ARADDR.
  - If both are eligible, the pointer's master wins. If one is eligible, it wins regardless of the pointer. If none, stay in IDLE.
  - On a win, latch the winner's index, its target, and the winner's ARID/ARADDR/ARLEN/ARSIZE/ARBURST; go to ADDR next cycle.
  - All outputs are 0 in IDLE.
- State ADDR:
  - Drive the latched payload on the shared bus and ARID_S = {2'b00, tag, ID}.
  - ARVALID is 1 for the target slave only.
  - ARREADY_master[grant] = ARREADY_slave[target]; the other master's ARREADY = 0.
  - Handshake (ARVALID & ARREADY at the target): next cycle set busy[target], point priority to the other master, go to IDLE.
  - No handshake: hold ADDR and all outputs stable. No timeout.
- Latency: master ARVALID at cycle N gives slave ARVALID at N+1 earliest; one accept per two cycles maximum.
- Busy clear: RVALID_x & RREADY_MtoSx & RLAST_x clears busy[x] on the next edge.
  - IDLE eligibility uses the registered busy, so a slave freed at edge N is grantable in the IDLE cycle following N.
  - Set and clear on the same slave in the same cycle cannot occur, because a busy slave is never granted. If it does occur, clear wins.
- A master whose target is busy is skipped; the other master may be served (no head-of-line blocking across masters).
- Unknown or unmapped addresses go to the default slave, which follows the same rules, including busy tracking.
- Inputs are sampled only at grant: master payload changes during ADDR are ignored.

Test Plan:
- Reset mid-ADDR (rst low with ARVALID_slave0 = 1) -> next cycle all outputs 0, busy = 0, and a master0 request is granted first.
- Single read: master0 ARVALID, ARADDR = 32'h0000_0040, ARID = 4'h3 -> cycle+1 ARVALID_slave0 = 1 and ARID_S = 8'h13. ARREADY_slave0 = 1 -> ARREADY_master0 = 1, busy[0] = 1.
- Both masters target slave1 simultaneously at reset priority -> master0 is granted and accepted. After the RLAST handshake on slave1, master1 is granted with ARID_S[5:4] = 2'b10.
- Busy bypass: slave0 busy; master0 requests 32'h0000_0100 and master1 requests 32'h0001_0000 -> master1 is granted to slave1 and master0 waits. RLAST on slave0 -> master0 is granted.
- Default decode: master1 ARADDR = 32'h1000_0000 -> only ARVALID_slaveDefault = 1. Holding ARREADY_slaveDefault = 0 for 5 cycles keeps the outputs stable.
- Round-robin: both masters continuously request distinct free slaves -> grants alternate M0, M1, M0, M1.

Source files
------------

// File: rtl/axi_ar_arbiter.sv
// ---------------------------------------------------------------------------
// axi_ar_arbiter
//
// Read-address (AR) channel arbiter and router for a 2-master / 3-slave AXI
// interconnect. This block is the control counterpart of the read-data (R)
// return mux.
//
// Function:
//   - Grants one master at a time. Priority between the masters is
//     round-robin.
//   - Decodes ARADDR to slave0, slave1 or the default slave.
//   - Tags the outgoing ID with a one-hot master tag in ARID_S[5:4]:
//     01 = master0, 10 = master1. The R mux routes responses on this tag.
//   - Allows one outstanding read per slave. A slave stays busy until its
//     RLAST beat is handshaked on the R channel.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   AR*_master0 / AR*_master1         master AR requests
//   ARREADY_master0/1                 request accepted (passes the target's ready)
//   ARID_S                            {2'b00, tag, ARID}, shared by all slaves
//   ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S   shared AR payload
//   ARVALID_slave0/1/Default          per-slave valid
//   ARREADY_slave0/1/Default          per-slave ready
//   RVALID_slave*/RREADY_MtoS*/RLAST_slave*   R channel, observed only
// ---------------------------------------------------------------------------

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_ar_arbiter #(
    parameter logic [`AXI_ADDR_BITS-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [`AXI_ADDR_BITS-1:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [`AXI_ADDR_BITS-1:0] S1_BASE = 32'h0001_0000,
    parameter logic [`AXI_ADDR_BITS-1:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic                       clk,
    input  logic                       rst,

    // master0 AR channel
    input  logic [`AXI_ID_BITS-1:0]    ARID_master0,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_master0,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_master0,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_master0,
    input  logic [1:0]                 ARBURST_master0,
    input  logic                       ARVALID_master0,
    output logic                       ARREADY_master0,

    // master1 AR channel
    input  logic [`AXI_ID_BITS-1:0]    ARID_master1,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_master1,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_master1,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_master1,
    input  logic [1:0]                 ARBURST_master1,
    input  logic                       ARVALID_master1,
    output logic                       ARREADY_master1,

    // shared slave-side AR payload
    output logic [`AXI_IDS_BITS-1:0]   ARID_S,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
    output logic [1:0]                 ARBURST_S,

    // per-slave AR handshake
    output logic                       ARVALID_slave0,
    output logic                       ARVALID_slave1,
    output logic                       ARVALID_slaveDefault,
    input  logic                       ARREADY_slave0,
    input  logic                       ARREADY_slave1,
    input  logic                       ARREADY_slaveDefault,

    // observed R channel, used only to retire outstanding reads
    input  logic                       RVALID_slave0,
    input  logic                       RVALID_slave1,
    input  logic                       RVALID_slaveDefault,
    input  logic                       RREADY_MtoS0,
    input  logic                       RREADY_MtoS1,
    input  logic                       RREADY_MtoSDefault,
    input  logic                       RLAST_slave0,
    input  logic                       RLAST_slave1,
    input  logic                       RLAST_slaveDefault
);

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } state_t;

    // Slave indices used for target and busy bookkeeping.
    localparam logic [1:0] TGT_S0  = 2'd0;
    localparam logic [1:0] TGT_S1  = 2'd1;
    localparam logic [1:0] TGT_DEF = 2'd2;

    localparam int ID_PAD = `AXI_IDS_BITS - `AXI_ID_BITS - 2;

    state_t      state;
    logic        grant_q;     // granted master index, valid in ADDR
    logic [1:0]  target_q;    // decoded target of the granted request
    logic [2:0]  busy;        // one outstanding read per slave
    logic        rr_ptr;      // master that wins a tie in IDLE

    logic [1:0]  tgt_m0;
    logic [1:0]  tgt_m1;
    logic        elig_m0;
    logic        elig_m1;
    logic        win_any;
    logic        win_master;
    logic [1:0]  win_target;
    logic [`AXI_ID_BITS-1:0]   win_id;
    logic [`AXI_ADDR_BITS-1:0] win_addr;
    logic [`AXI_LEN_BITS-1:0]  win_len;
    logic [`AXI_SIZE_BITS-1:0] win_size;
    logic [1:0]  win_burst;
    logic [1:0]  win_tag;

    logic        target_ready;
    logic        addr_hs;
    logic [2:0]  busy_set;
    logic [2:0]  r_done;

    // Address decode: slave0 has precedence over slave1, anything that hits
    // neither window goes to the default slave.
    function automatic logic [1:0] decode(input logic [`AXI_ADDR_BITS-1:0] addr);
        logic [1:0] tgt;
        if ((addr & S0_MASK) == S0_BASE) begin
            tgt = TGT_S0;
        end else if ((addr & S1_MASK) == S1_BASE) begin
            tgt = TGT_S1;
        end else begin
            tgt = TGT_DEF;
        end
        return tgt;
    endfunction

    assign tgt_m0 = decode(ARADDR_master0);
    assign tgt_m1 = decode(ARADDR_master1);

    // A master whose target is busy is simply not eligible, so the other
    // master can still be served (no head-of-line blocking across masters).
    assign elig_m0 = ARVALID_master0 && !busy[tgt_m0];
    assign elig_m1 = ARVALID_master1 && !busy[tgt_m1];
    assign win_any = elig_m0 || elig_m1;

    // The pointer only matters on a tie; a lone eligible master always wins.
    assign win_master = (elig_m0 && elig_m1) ? rr_ptr : elig_m1;

    // Payload of whichever master wins this cycle's arbitration.
    always_comb begin
        win_target = tgt_m0;
        win_id     = ARID_master0;
        win_addr   = ARADDR_master0;
        win_len    = ARLEN_master0;
        win_size   = ARSIZE_master0;
        win_burst  = ARBURST_master0;
        win_tag    = 2'b01;
        if (win_master) begin
            win_target = tgt_m1;
            win_id     = ARID_master1;
            win_addr   = ARADDR_master1;
            win_len    = ARLEN_master1;
            win_size   = ARSIZE_master1;
            win_burst  = ARBURST_master1;
            win_tag    = 2'b10;
        end
    end

    // Ready of the slave the granted request is routed to.
    always_comb begin
        target_ready = 1'b0;
        case (target_q)
            TGT_S0:  target_ready = ARREADY_slave0;
            TGT_S1:  target_ready = ARREADY_slave1;
            TGT_DEF: target_ready = ARREADY_slaveDefault;
            default: target_ready = 1'b0;
        endcase
    end

    assign addr_hs  = (state == ADDR) && target_ready;
    assign busy_set = addr_hs ? (3'b001 << target_q) : 3'b000;

    // Last R beat handshaked on a slave retires its single outstanding read.
    assign r_done = {RVALID_slaveDefault & RREADY_MtoSDefault & RLAST_slaveDefault,
                     RVALID_slave1       & RREADY_MtoS1       & RLAST_slave1,
                     RVALID_slave0       & RREADY_MtoS0       & RLAST_slave0};

    // The master ready is a pass-through of the target's ready, only for the
    // granted master and only while the request is being presented.
    assign ARREADY_master0 = (state == ADDR) && !grant_q && target_ready;
    assign ARREADY_master1 = (state == ADDR) &&  grant_q && target_ready;

    // Arbitration FSM. The shared payload and the per-slave valids are
    // registered: they are loaded at grant, held for the whole ADDR state
    // regardless of what the masters do, and cleared on the handshake so
    // that everything reads zero in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            grant_q              <= 1'b0;
            target_q             <= TGT_S0;
            busy                 <= 3'b000;
            rr_ptr               <= 1'b0;
            ARID_S               <= '0;
            ARADDR_S             <= '0;
            ARLEN_S              <= '0;
            ARSIZE_S             <= '0;
            ARBURST_S            <= '0;
            ARVALID_slave0       <= 1'b0;
            ARVALID_slave1       <= 1'b0;
            ARVALID_slaveDefault <= 1'b0;
        end else begin
            // Clear is applied after set so that it wins if both ever hit
            // the same slave in one cycle.
            busy <= (busy | busy_set) & ~r_done;

            case (state)
                IDLE: begin
                    if (win_any) begin
                        state                <= ADDR;
                        grant_q              <= win_master;
                        target_q             <= win_target;
                        ARID_S               <= {{ID_PAD{1'b0}}, win_tag, win_id};
                        ARADDR_S             <= win_addr;
                        ARLEN_S              <= win_len;
                        ARSIZE_S             <= win_size;
                        ARBURST_S            <= win_burst;
                        ARVALID_slave0       <= (win_target == TGT_S0);
                        ARVALID_slave1       <= (win_target == TGT_S1);
                        ARVALID_slaveDefault <= (win_target == TGT_DEF);
                    end
                end

                ADDR: begin
                    if (target_ready) begin
                        state                <= IDLE;
                        rr_ptr               <= ~grant_q;
                        ARID_S               <= '0;
                        ARADDR_S             <= '0;
                        ARLEN_S              <= '0;
                        ARSIZE_S             <= '0;
                        ARBURST_S            <= '0;
                        ARVALID_slave0       <= 1'b0;
                        ARVALID_slave1       <= 1'b0;
                        ARVALID_slaveDefault <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
